// File: rtl/lcd_spi_receiver.sv
// rtl/lcd_spi_receiver.sv - serial LCD bus receiver producing display-RAM writes and command strobes
module lcd_spi_receiver #(
    parameter logic [6:0] COL_LAST = 7'd127
) (
    input  logic        CLOCK,
    input  logic        RST_n,
    input  logic [3:0]  SPI_In,
    output logic        Ram_Wr_En,
    output logic [9:0]  Ram_Addr,
    output logic [7:0]  Ram_Data,
    output logic        Cmd_Valid,
    output logic [7:0]  Cmd_Byte,
    output logic        Frame_Err,
    output logic [15:0] Data_Count
);

    typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} state_t;

    // Synchronizer idle value keeps CS_n deasserted and SCLK low.
    localparam logic [3:0] SYNC_RST = 4'b1000;

    state_t      state_q, state_d;
    logic [3:0]  sync1_q, sync1_d, sync2_q, sync2_d;
    logic        sclk_prev_q, sclk_prev_d;
    logic [2:0]  bit_cnt_q, bit_cnt_d;
    logic [7:0]  shift_q, shift_d;
    logic        a0_q, a0_d;
    logic [2:0]  page_q, page_d;
    logic [6:0]  col_q, col_d;
    logic        ram_wr_en_q, ram_wr_en_d;
    logic [9:0]  ram_addr_q, ram_addr_d;
    logic [7:0]  ram_data_q, ram_data_d;
    logic        cmd_valid_q, cmd_valid_d;
    logic [7:0]  cmd_byte_q, cmd_byte_d;
    logic        frame_err_q, frame_err_d;
    logic [15:0] data_count_q, data_count_d;

    logic cs_n;
    logic sclk_rise;

    assign cs_n      = sync2_q[3];
    assign sclk_rise = sync2_q[1] & ~sclk_prev_q;

    always_comb begin
        state_d      = state_q;
        sync1_d      = SPI_In;
        sync2_d      = sync1_q;
        sclk_prev_d  = sync2_q[1];
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        a0_d         = a0_q;
        page_d       = page_q;
        col_d        = col_q;
        ram_wr_en_d  = 1'b0;
        ram_addr_d   = ram_addr_q;
        ram_data_d   = ram_data_q;
        cmd_valid_d  = 1'b0;
        cmd_byte_d   = cmd_byte_q;
        frame_err_d  = 1'b0;
        data_count_d = data_count_q;

        case (state_q)
            IDLE: begin
                bit_cnt_d = 3'd0;
                if (!cs_n) begin
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                // A clock edge wins over a simultaneous CS_n rise; the rise is seen next cycle.
                if (sclk_rise) begin
                    shift_d   = {shift_q[6:0], sync2_q[0]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        a0_d    = sync2_q[2];
                        state_d = COMMIT;
                    end
                end else if (cs_n) begin
                    frame_err_d = (bit_cnt_q != 3'd0);
                    bit_cnt_d   = 3'd0;
                    state_d     = IDLE;
                end
            end
            COMMIT: begin
                if (a0_q) begin
                    ram_wr_en_d  = 1'b1;
                    ram_data_d   = shift_q;
                    ram_addr_d   = {page_q, col_q};
                    data_count_d = data_count_q + 16'd1;
                    col_d        = (col_q == COL_LAST) ? 7'd0 : col_q + 7'd1;
                end else begin
                    cmd_valid_d = 1'b1;
                    cmd_byte_d  = shift_q;
                    if (shift_q[7:3] == 5'b10110) begin
                        page_d = shift_q[2:0];
                    end else if (shift_q[7:4] == 4'h1) begin
                        col_d[6:4] = shift_q[2:0];
                    end else if (shift_q[7:4] == 4'h0) begin
                        col_d[3:0] = shift_q[3:0];
                    end
                end
                state_d = cs_n ? IDLE : SHIFT;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLOCK or negedge RST_n) begin
        if (!RST_n) begin
            state_q      <= IDLE;
            sync1_q      <= SYNC_RST;
            sync2_q      <= SYNC_RST;
            sclk_prev_q  <= 1'b0;
            bit_cnt_q    <= 3'd0;
            shift_q      <= 8'd0;
            a0_q         <= 1'b0;
            page_q       <= 3'd0;
            col_q        <= 7'd0;
            ram_wr_en_q  <= 1'b0;
            ram_addr_q   <= 10'd0;
            ram_data_q   <= 8'd0;
            cmd_valid_q  <= 1'b0;
            cmd_byte_q   <= 8'd0;
            frame_err_q  <= 1'b0;
            data_count_q <= 16'd0;
        end else begin
            state_q      <= state_d;
            sync1_q      <= sync1_d;
            sync2_q      <= sync2_d;
            sclk_prev_q  <= sclk_prev_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            a0_q         <= a0_d;
            page_q       <= page_d;
            col_q        <= col_d;
            ram_wr_en_q  <= ram_wr_en_d;
            ram_addr_q   <= ram_addr_d;
            ram_data_q   <= ram_data_d;
            cmd_valid_q  <= cmd_valid_d;
            cmd_byte_q   <= cmd_byte_d;
            frame_err_q  <= frame_err_d;
            data_count_q <= data_count_d;
        end
    end

    assign Ram_Wr_En  = ram_wr_en_q;
    assign Ram_Addr   = ram_addr_q;
    assign Ram_Data   = ram_data_q;
    assign Cmd_Valid  = cmd_valid_q;
    assign Cmd_Byte   = cmd_byte_q;
    assign Frame_Err  = frame_err_q;
    assign Data_Count = data_count_q;

endmodule

// File: tb/tb_lcd_spi_receiver.sv
// tb/tb_lcd_spi_receiver.sv - randomized scoreboard bench for lcd_spi_receiver
module tb_lcd_spi_receiver;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cs = 1'b1, a0 = 1'b0, sclk = 1'b0, sda = 1'b0;
    logic        Ram_Wr_En, Cmd_Valid, Frame_Err;
    logic [9:0]  Ram_Addr;
    logic [7:0]  Ram_Data, Cmd_Byte;
    logic [15:0] Data_Count;

    int tests = 0;
    int fails = 0;

    lcd_spi_receiver dut (
        .CLOCK(clk), .RST_n(rst_n), .SPI_In({cs, a0, sclk, sda}),
        .Ram_Wr_En(Ram_Wr_En), .Ram_Addr(Ram_Addr), .Ram_Data(Ram_Data),
        .Cmd_Valid(Cmd_Valid), .Cmd_Byte(Cmd_Byte), .Frame_Err(Frame_Err),
        .Data_Count(Data_Count)
    );

    always #5 clk = ~clk;

    // Observed strobes, captured away from the active edge.
    logic [17:0] obs_wr[$];
    logic [7:0]  obs_cmd[$];
    int          ferr_cnt = 0;
    int          both_cnt = 0;

    always @(negedge clk) begin
        if (rst_n) begin
            if (Ram_Wr_En) obs_wr.push_back({Ram_Addr, Ram_Data});
            if (Cmd_Valid) obs_cmd.push_back(Cmd_Byte);
            if (Frame_Err) ferr_cnt++;
            if (Ram_Wr_En && Cmd_Valid) both_cnt++;
        end
    end

    // Reference model: display address pointer and expected strobe streams.
    int          m_page = 0, m_col = 0, m_cnt = 0;
    logic [17:0] exp_wr[$];
    logic [7:0]  exp_cmd[$];

    function automatic void model_byte(input logic is_data, input logic [7:0] b);
        int v;
        v = b;
        if (is_data) begin
            exp_wr.push_back({10'(m_page * 128 + m_col), b});
            m_cnt = (m_cnt + 1) % 65536;
            m_col = (m_col == 127) ? 0 : m_col + 1;
        end else begin
            exp_cmd.push_back(b);
            if (v >= 'hB0 && v <= 'hB7)      m_page = v - 'hB0;
            else if (v >= 'h10 && v <= 'h1F) m_col = (m_col % 16) + (v % 8) * 16;
            else if (v <= 'h0F)              m_col = (m_col / 16) * 16 + v;
        end
    endfunction

    function automatic void model_reset();
        m_page = 0; m_col = 0; m_cnt = 0;
        exp_wr.delete(); exp_cmd.delete();
    endfunction

    task automatic send_bits(input logic a0v, input logic [7:0] b, input int nbits, input int half);
        cs = 1'b0;
        a0 = a0v;
        for (int i = 7; i > 7 - nbits; i--) begin
            sclk = 1'b0; sda = b[i];
            repeat (half) @(negedge clk);
            sclk = 1'b1;
            repeat (half) @(negedge clk);
        end
        sclk = 1'b0;
        repeat (half) @(negedge clk);
    endtask

    task automatic send_byte(input logic a0v, input logic [7:0] b);
        send_bits(a0v, b, 8, 3);
        model_byte(a0v, b);
    endtask

    task automatic cs_high();
        cs = 1'b1;
        repeat (8) @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        tests++; if (Ram_Wr_En !== 1'b0)   begin fails++; $display("FAIL rst_wr_en got %0b want 0", Ram_Wr_En); end
        tests++; if (Ram_Addr !== 10'd0)   begin fails++; $display("FAIL rst_addr got %0d want 0", Ram_Addr); end
        tests++; if (Ram_Data !== 8'd0)    begin fails++; $display("FAIL rst_data got %0h want 0", Ram_Data); end
        tests++; if (Cmd_Valid !== 1'b0)   begin fails++; $display("FAIL rst_cmd_valid got %0b want 0", Cmd_Valid); end
        tests++; if (Cmd_Byte !== 8'd0)    begin fails++; $display("FAIL rst_cmd_byte got %0h want 0", Cmd_Byte); end
        tests++; if (Frame_Err !== 1'b0)   begin fails++; $display("FAIL rst_frame_err got %0b want 0", Frame_Err); end
        tests++; if (Data_Count !== 16'd0) begin fails++; $display("FAIL rst_count got %0d want 0", Data_Count); end
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        model_reset();
    endtask

    task automatic test_cmd_addr();
        logic [17:0] o, e;
        send_byte(1'b0, 8'hB2);
        send_byte(1'b0, 8'h10);
        send_byte(1'b0, 8'h05);
        send_byte(1'b1, 8'hA5);
        cs_high();
        tests++; if (exp_wr.size() == 1 && exp_wr[0] !== {10'd261, 8'hA5}) begin fails++; $display("FAIL addr_model got %0h want %0h", exp_wr[0], {10'd261, 8'hA5}); end
        tests++; if (obs_cmd.size() != 3) begin fails++; $display("FAIL addr_cmd_count got %0d want 3", obs_cmd.size()); end
        tests++; if (obs_wr.size() != exp_wr.size()) begin fails++; $display("FAIL addr_wr_count got %0d want %0d", obs_wr.size(), exp_wr.size()); end
        while (obs_wr.size() > 0 && exp_wr.size() > 0) begin
            o = obs_wr.pop_front(); e = exp_wr.pop_front();
            tests++; if (o !== e) begin fails++; $display("FAIL addr_wr got %0h want %0h", o, e); end
        end
        while (obs_cmd.size() > 0 && exp_cmd.size() > 0) begin
            o = 18'(obs_cmd.pop_front()); e = 18'(exp_cmd.pop_front());
            tests++; if (o !== e) begin fails++; $display("FAIL addr_cmd got %0h want %0h", o, e); end
        end
        tests++; if (Data_Count !== 16'(m_cnt)) begin fails++; $display("FAIL addr_count got %0d want %0d", Data_Count, m_cnt); end
        obs_wr.delete(); obs_cmd.delete(); exp_wr.delete(); exp_cmd.delete();
    endtask

    task automatic test_col_wrap();
        logic [17:0] o, e;
        send_byte(1'b0, 8'hB0);
        send_byte(1'b0, 8'h17);
        send_byte(1'b0, 8'h0F);
        send_byte(1'b1, 8'h11);
        send_byte(1'b1, 8'h22);
        cs_high();
        tests++; if (obs_wr.size() != 2) begin fails++; $display("FAIL wrap_wr_count got %0d want 2", obs_wr.size()); end
        while (obs_wr.size() > 0 && exp_wr.size() > 0) begin
            o = obs_wr.pop_front(); e = exp_wr.pop_front();
            tests++; if (o !== e) begin fails++; $display("FAIL wrap_wr got %0h want %0h", o, e); end
        end
        tests++; if (Data_Count !== 16'(m_cnt)) begin fails++; $display("FAIL wrap_count got %0d want %0d", Data_Count, m_cnt); end
        obs_wr.delete(); obs_cmd.delete(); exp_wr.delete(); exp_cmd.delete();
    endtask

    task automatic test_frame_err();
        logic [17:0] o, e;
        ferr_cnt = 0;
        send_bits(1'b1, 8'h5A, 5, 3);
        cs_high();
        tests++; if (ferr_cnt != 1) begin fails++; $display("FAIL ferr_pulse got %0d want 1", ferr_cnt); end
        tests++; if (obs_wr.size() + obs_cmd.size() != 0) begin fails++; $display("FAIL ferr_strobe got %0d want 0", obs_wr.size() + obs_cmd.size()); end
        send_byte(1'b1, 8'h3C);
        cs_high();
        tests++; if (ferr_cnt != 1) begin fails++; $display("FAIL ferr_after got %0d want 1", ferr_cnt); end
        tests++; if (obs_wr.size() != 1) begin fails++; $display("FAIL ferr_wr_count got %0d want 1", obs_wr.size()); end
        while (obs_wr.size() > 0 && exp_wr.size() > 0) begin
            o = obs_wr.pop_front(); e = exp_wr.pop_front();
            tests++; if (o !== e) begin fails++; $display("FAIL ferr_wr got %0h want %0h", o, e); end
        end
        obs_wr.delete(); obs_cmd.delete(); exp_wr.delete(); exp_cmd.delete();
    endtask

    task automatic test_other_cmd();
        logic [17:0] o, e;
        send_byte(1'b0, 8'hAF);
        send_byte(1'b1, 8'h77);
        cs_high();
        tests++; if (obs_cmd.size() != 1 || obs_cmd[0] !== 8'hAF) begin fails++; $display("FAIL other_cmd got %0d cmds want one AF", obs_cmd.size()); end
        tests++; if (Cmd_Byte !== 8'hAF) begin fails++; $display("FAIL other_hold got %0h want af", Cmd_Byte); end
        tests++; if (obs_wr.size() != 1) begin fails++; $display("FAIL other_wr_count got %0d want 1", obs_wr.size()); end
        while (obs_wr.size() > 0 && exp_wr.size() > 0) begin
            o = obs_wr.pop_front(); e = exp_wr.pop_front();
            tests++; if (o !== e) begin fails++; $display("FAIL other_wr got %0h want %0h", o, e); end
        end
        obs_wr.delete(); obs_cmd.delete(); exp_wr.delete(); exp_cmd.delete();
    endtask

    task automatic test_random();
        logic [17:0] o, e;
        logic [7:0]  b;
        logic        d;
        int          half;
        for (int n = 0; n < 48; n++) begin
            d = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 3))
                0: b = 8'hB0 + 8'($urandom_range(0, 7));
                1: b = 8'h10 + 8'($urandom_range(0, 15));
                2: b = 8'($urandom_range(0, 15));
                default: b = 8'($urandom);
            endcase
            half = $urandom_range(3, 5);
            send_bits(d, b, 8, half);
            model_byte(d, b);
            if ($urandom_range(0, 3) == 0) cs_high();
        end
        cs_high();
        tests++; if (obs_wr.size() != exp_wr.size()) begin fails++; $display("FAIL rand_wr_count got %0d want %0d", obs_wr.size(), exp_wr.size()); end
        tests++; if (obs_cmd.size() != exp_cmd.size()) begin fails++; $display("FAIL rand_cmd_count got %0d want %0d", obs_cmd.size(), exp_cmd.size()); end
        while (obs_wr.size() > 0 && exp_wr.size() > 0) begin
            o = obs_wr.pop_front(); e = exp_wr.pop_front();
            tests++; if (o !== e) begin fails++; $display("FAIL rand_wr got %0h want %0h", o, e); end
        end
        while (obs_cmd.size() > 0 && exp_cmd.size() > 0) begin
            o = 18'(obs_cmd.pop_front()); e = 18'(exp_cmd.pop_front());
            tests++; if (o !== e) begin fails++; $display("FAIL rand_cmd got %0h want %0h", o, e); end
        end
        tests++; if (Data_Count !== 16'(m_cnt)) begin fails++; $display("FAIL rand_count got %0d want %0d", Data_Count, m_cnt); end
        obs_wr.delete(); obs_cmd.delete(); exp_wr.delete(); exp_cmd.delete();
    endtask

    task automatic test_reset_mid_byte();
        logic [17:0] o, e;
        send_bits(1'b1, 8'hFF, 4, 3);
        ferr_cnt = 0;
        rst_n = 1'b0;
        #1;
        tests++; if ({Ram_Wr_En, Ram_Addr, Ram_Data, Cmd_Valid, Cmd_Byte, Frame_Err, Data_Count} !== '0) begin
            fails++; $display("FAIL midrst_outputs got addr %0d data %0h cmd %0h cnt %0d want all 0", Ram_Addr, Ram_Data, Cmd_Byte, Data_Count);
        end
        cs = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        obs_wr.delete(); obs_cmd.delete();
        repeat (4) @(negedge clk);
        send_byte(1'b1, 8'h80);
        cs_high();
        tests++; if (ferr_cnt != 0) begin fails++; $display("FAIL midrst_ferr got %0d want 0", ferr_cnt); end
        tests++; if (obs_wr.size() != 1 || obs_wr[0] !== {10'd0, 8'h80}) begin fails++; $display("FAIL midrst_wr got %0d writes want one 0x80 at 0", obs_wr.size()); end
        while (obs_wr.size() > 0 && exp_wr.size() > 0) begin
            o = obs_wr.pop_front(); e = exp_wr.pop_front();
            tests++; if (o !== e) begin fails++; $display("FAIL midrst_model got %0h want %0h", o, e); end
        end
        obs_wr.delete(); obs_cmd.delete(); exp_wr.delete(); exp_cmd.delete();
    endtask

    task automatic test_fill();
        logic [17:0] o, e;
        int          hits[1024];
        int          bad;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        obs_wr.delete(); obs_cmd.delete();
        repeat (3) @(negedge clk);
        foreach (hits[i]) hits[i] = 0;
        for (int p = 0; p < 8; p++) begin
            send_byte(1'b0, 8'hB0 + 8'(p));
            send_byte(1'b0, 8'h10);
            send_byte(1'b0, 8'h00);
            for (int c = 0; c < 128; c++) send_byte(1'b1, 8'($urandom));
        end
        cs_high();
        tests++; if (obs_wr.size() != 1024) begin fails++; $display("FAIL fill_wr_count got %0d want 1024", obs_wr.size()); end
        while (obs_wr.size() > 0 && exp_wr.size() > 0) begin
            o = obs_wr.pop_front(); e = exp_wr.pop_front();
            hits[o[17:8]]++;
            tests++; if (o !== e) begin fails++; $display("FAIL fill_wr got %0h want %0h", o, e); end
        end
        bad = 0;
        foreach (hits[i]) if (hits[i] != 1) bad++;
        tests++; if (bad != 0) begin fails++; $display("FAIL fill_coverage got %0d addresses not written once want 0", bad); end
        tests++; if (Data_Count !== 16'd1024) begin fails++; $display("FAIL fill_count got %0d want 1024", Data_Count); end
        obs_wr.delete(); obs_cmd.delete(); exp_wr.delete(); exp_cmd.delete();
    endtask

    initial begin
        test_reset();
        test_cmd_addr();
        test_col_wrap();
        test_frame_err();
        test_other_cmd();
        test_random();
        test_reset_mid_byte();
        test_fill();
        tests++; if (both_cnt != 0) begin fails++; $display("FAIL strobe_overlap got %0d want 0", both_cnt); end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
